two_phase_handshake_sender: RTL and testbench
=============================================

// Module: two_phase_handshake_sender
// PURPOSE
//  Sequences a toggle register as the request line of a 2-phase (transition-signalled) handshake.
//  Accepts words on a local ready/valid port and holds each word stable on request_data.
//  Signals each new word by toggling request, then waits for the receiver's acknowledge to match.
//  Sits at the sending edge of a clock-domain crossing; the receiver runs on an unrelated clock.
// PARAMETERS
//  WORD_WIDTH      0   data width; must be overridden, >= 1
//  SYNC_DEPTH      2   acknowledge synchronizer flop stages, >= 2
//  TIMEOUT_CYCLES  0   cycles in WAIT_ACK before a timeout pulse; 0 disables timeout logic
// PORTS
//  clock           in   1           single clock; all state updates on rising edge
//  clear           in   1           synchronous, active-high reset
//  input_valid     in   1           local word available
//  input_ready     out  1           sender can accept a word
//  input_data      in   WORD_WIDTH  local word
//  request         out  1           2-phase request; each transition announces a new word
//  request_data    out  WORD_WIDTH  registered word, stable while busy
//  acknowledge     in   1           2-phase ack from receiver domain; asynchronous to clock
//  busy            out  1           transaction outstanding
//  timeout         out  1           one-cycle pulse: ack overdue
//  protocol_error  out  1           one-cycle pulse: ack changed while no transaction was outstanding
// BEHAVIOUR
//  - Reset (clear=1): request=0, request_data=0, busy=0, timeout=0, protocol_error=0.
//    Synchronizer flops=0, timeout counter=0, state=IDLE. input_ready=1 on the cycle after clear drops.
//  - Clear is honoured in any state. It takes effect the same edge and overrides all other inputs.
//    It abandons an outstanding transaction; the receiver must be cleared in step by the system.
//  - ack_sync: acknowledge passed through SYNC_DEPTH flops.
//    A change on acknowledge is visible SYNC_DEPTH cycles later.
//  - FSM, two states:
//    IDLE:
//      - input_ready=1, busy=0.
//      - On input_valid & input_ready: latch input_data into request_data and toggle request.
//        Both take effect at the same edge, so both are visible the next cycle. Go to WAIT_ACK.
//    WAIT_ACK:
//      - input_ready=0, busy=1, request_data and request held.
//      - When ack_sync == request: transaction complete; go to IDLE.
//  - input_ready is decoded from the state only, never from input_valid or acknowledge.
//    Completion and a new input_valid in the same cycle: the word is accepted the next cycle at the earliest.
//  - Throughput: at most one word per (receiver round trip + SYNC_DEPTH + 2) cycles.
//  - Timeout (TIMEOUT_CYCLES>0):
//    - Counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
//    - On reaching TIMEOUT_CYCLES, pulse timeout for exactly one cycle.
//    - The counter then saturates: no repeat pulse, no retransmit, state remains WAIT_ACK.
//    - A late ack still completes the transaction normally.
//  - Protocol error: in IDLE, ack_sync != request pulses protocol_error once per change of ack_sync.
//    The event is otherwise ignored; no state change.
//  - Counter width clog2(TIMEOUT_CYCLES+1); no wrap-around possible.
//    With TIMEOUT_CYCLES=0, timeout is tied 0 and the counter is not generated.
// STRUCTURE
//  - Sub-module: Register_Toggle (WORD_WIDTH=1, RESET_VALUE=0) holds request.
//    Its toggle input = accept strobe, clock_enable=1, clear=clear.
//  - Data word: plain Register, clock_enable = accept strobe.
//  - Synchronizer, FSM and timeout counter are local.
//  - No shared package: state encodings are local constants, IDLE=0, WAIT_ACK=1.
//  - The phase convention "complete when ack == request" is local and documented here only.
// TESTING
//  1. Clear for 3 cycles, release -> request=0, request_data=0, busy=0; input_ready=1 on the next cycle.
//  2. input_data=8'hA5 valid 1 cycle (WORD_WIDTH=8) -> next cycle request=1, request_data=8'hA5, busy=1.
//     Then toggle ack to 1 -> busy=0 exactly SYNC_DEPTH+1 cycles later.
//  3. Back-to-back words 8'h01, 8'h02 with ack model echoing after 5 cycles
//     -> request sequence 1,0; each word held until matched; no word lost or duplicated.
//  4. TIMEOUT_CYCLES=10, ack withheld -> timeout single pulse 10 cycles after WAIT_ACK entry, none after.
//     Then ack -> IDLE.
//  5. Ack toggled while IDLE -> protocol_error single pulse SYNC_DEPTH cycles later; state stays IDLE.
//  6. Clear asserted in WAIT_ACK with request=1 -> next cycle request=0, busy=0, input_ready=1; no timeout pulse.

Source files
------------

// File: rtl/two_phase_handshake_sender_pkg.sv
// Shared helpers for the two-phase handshake sender slice.
package two_phase_handshake_sender_pkg;

    // Width of a counter that must hold values 0..max_count without wrapping.
    function automatic int counter_width(input int max_count);
        if (max_count < 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(max_count + 32'sd1);
        end
    endfunction

endpackage

// File: rtl/two_phase_handshake_sender_toggle.sv
// Toggle register: each enabled edge XORs the toggle mask into the held value.
module two_phase_handshake_sender_toggle
    import two_phase_handshake_sender_pkg::*;
#(
    parameter int                    WORD_WIDTH  = 1,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  clock_enable,
    input  logic                  clear,
    input  logic [WORD_WIDTH-1:0] toggle,
    output logic [WORD_WIDTH-1:0] data_out
);

    logic [WORD_WIDTH-1:0] data_q;
    logic [WORD_WIDTH-1:0] data_d;

    // Next value: flip the selected bits when enabled.
    always_comb begin
        data_d = data_q;
        if (clock_enable) begin
            data_d = data_q ^ toggle;
        end else begin
            data_d = data_q;
        end
    end

    // Held value with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/two_phase_handshake_sender.sv
// Sending side of a 2-phase request/acknowledge crossing: one word in flight,
// announced by a request transition and retired when the synchronized ack matches request.
module two_phase_handshake_sender
    import two_phase_handshake_sender_pkg::*;
#(
    parameter int WORD_WIDTH     = 0,
    parameter int SYNC_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [WORD_WIDTH-1:0] input_data,
    output logic                  request,
    output logic [WORD_WIDTH-1:0] request_data,
    input  logic                  acknowledge,
    output logic                  busy,
    output logic                  timeout,
    output logic                  protocol_error
);

    localparam logic [0:0] STATE_IDLE     = 1'b0;
    localparam logic [0:0] STATE_WAIT_ACK = 1'b1;

    logic [0:0]            state_q;
    logic [0:0]            state_d;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic [SYNC_DEPTH-1:0] sync_d;
    logic [WORD_WIDTH-1:0] data_q;
    logic [WORD_WIDTH-1:0] data_d;
    logic                  perr_q;
    logic                  perr_d;

    logic ack_sync;
    logic accept;
    logic complete;
    logic request_next;

    assign ack_sync     = sync_q[SYNC_DEPTH-1];
    assign accept       = (state_q == STATE_IDLE) && input_valid;
    // Phase convention: the transaction is done once the ack phase equals the request phase.
    assign complete     = (state_q == STATE_WAIT_ACK) && (ack_sync == request);
    assign request_next = request ^ accept;

    two_phase_handshake_sender_toggle #(
        .WORD_WIDTH  (1),
        .RESET_VALUE (1'b0)
    ) u_request (
        .clock        (clock),
        .clock_enable (1'b1),
        .clear        (clear),
        .toggle       (accept),
        .data_out     (request)
    );

    // Next state, synchronizer shift, word capture and protocol-error detection.
    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[SYNC_DEPTH-2:0], acknowledge};
        data_d  = data_q;
        perr_d  = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    state_d = STATE_WAIT_ACK;
                end else begin
                    state_d = STATE_IDLE;
                end
            end
            STATE_WAIT_ACK: begin
                if (complete) begin
                    state_d = STATE_IDLE;
                end else begin
                    state_d = STATE_WAIT_ACK;
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
        if (accept) begin
            data_d = input_data;
        end else begin
            data_d = data_q;
        end
        // Judged on post-edge values so the pulse lands SYNC_DEPTH cycles after the ack change.
        if ((state_d == STATE_IDLE) && (sync_d[SYNC_DEPTH-1] != ack_sync)
                && (sync_d[SYNC_DEPTH-1] != request_next)) begin
            perr_d = 1'b1;
        end else begin
            perr_d = 1'b0;
        end
    end

    // Control, synchronizer and data registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= STATE_IDLE;
            sync_q  <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int               CW       = counter_width(TIMEOUT_CYCLES);
            localparam logic [CW-1:0]    LIMIT    = CW'(TIMEOUT_CYCLES);
            localparam logic [CW-1:0]    LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;
            logic          timeout_q;
            logic          timeout_d;

            // Wait counter: restarts on accept, saturates at the limit so it fires only once.
            always_comb begin
                count_d   = count_q;
                timeout_d = 1'b0;
                if (accept) begin
                    count_d = '0;
                end else if ((state_q == STATE_WAIT_ACK) && !complete && (count_q != LIMIT)) begin
                    count_d   = count_q + CW'(1'b1);
                    timeout_d = (count_q == LIMIT_M1);
                end else begin
                    count_d = count_q;
                end
            end

            // Counter and registered timeout pulse.
            always_ff @(posedge clock) begin
                if (clear) begin
                    count_q   <= '0;
                    timeout_q <= 1'b0;
                end else begin
                    count_q   <= count_d;
                    timeout_q <= timeout_d;
                end
            end

            assign timeout = timeout_q;
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    assign input_ready    = (state_q == STATE_IDLE);
    assign busy           = (state_q == STATE_WAIT_ACK);
    assign request_data   = data_q;
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_two_phase_handshake_sender.sv
// Directed bench for two_phase_handshake_sender with a cycle-level behavioural model.
module tb_two_phase_handshake_sender;

    localparam int WW = 8;
    localparam int SD = 2;
    localparam int TC = 10;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [WW-1:0] input_data = '0;
    logic          request;
    logic [WW-1:0] request_data;
    logic          acknowledge;
    logic          busy;
    logic          timeout;
    logic          protocol_error;

    logic man_ack = 1'b0;
    logic resp_ack = 1'b0;
    logic resp_en = 1'b0;
    logic resp_last = 1'b0;
    int   resp_dly = 0;
    logic [WW-1:0] got_words[$];
    logic          got_reqs[$];

    int n_pass = 0;
    int n_total = 0;

    assign acknowledge = resp_en ? resp_ack : man_ack;

    always #5 clk = ~clk;

    two_phase_handshake_sender #(
        .WORD_WIDTH     (WW),
        .SYNC_DEPTH     (SD),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clock          (clk),
        .clear          (clear),
        .input_valid    (input_valid),
        .input_ready    (input_ready),
        .input_data     (input_data),
        .request        (request),
        .request_data   (request_data),
        .acknowledge    (acknowledge),
        .busy           (busy),
        .timeout        (timeout),
        .protocol_error (protocol_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          smp_clear, smp_valid, smp_ack;
    logic [WW-1:0] smp_data;
    always @(posedge clk) begin
        smp_clear <= clear;
        smp_valid <= input_valid;
        smp_ack   <= acknowledge;
        smp_data  <= input_data;
    end

    bit            ack_at[0:4095];
    int            edge_n = 0;
    int            last_clear = -1;
    bit            chk_en = 1'b0;
    bit            m_busy = 1'b0;
    bit            m_req = 1'b0;
    logic [WW-1:0] m_data = '0;
    int            m_wait = 0;
    bit            m_to = 1'b0;
    bit            m_pe = 1'b0;

    // Ack as seen by the sender after edge k: the value acknowledge had SD-1 edges earlier.
    function automatic bit sync_of(input int k);
        int idx;
        idx = k - SD + 1;
        if (idx <= last_clear || idx < 0) return 1'b0;
        return ack_at[idx];
    endfunction

    task automatic model_step();
        bit s_before, s_after;
        edge_n++;
        ack_at[edge_n] = smp_ack;
        m_to = 1'b0;
        m_pe = 1'b0;
        if (smp_clear) begin
            m_busy = 1'b0; m_req = 1'b0; m_data = '0; m_wait = 0;
            last_clear = edge_n;
            chk_en = 1'b1;
        end else begin
            s_before = sync_of(edge_n - 1);
            s_after  = sync_of(edge_n);
            if (!m_busy) begin
                if (smp_valid) begin
                    m_busy = 1'b1; m_req = ~m_req; m_data = smp_data; m_wait = 0;
                end
            end else if (s_before == m_req) begin
                m_busy = 1'b0;
            end else begin
                m_wait++;
                if (m_wait == TC) m_to = 1'b1;
            end
            if (!m_busy && (s_after != m_req) && (s_after != s_before)) m_pe = 1'b1;
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        model_step();
        if (chk_en) begin
            check("cyc request",        32'(request),        32'(m_req));
            check("cyc request_data",   32'(request_data),   32'(m_data));
            check("cyc busy",           32'(busy),           32'(m_busy));
            check("cyc input_ready",    32'(input_ready),    32'(!m_busy));
            check("cyc timeout",        32'(timeout),        32'(m_to));
            check("cyc protocol_error", 32'(protocol_error), 32'(m_pe));
        end
    end

    // Receiver stand-in: echoes request 5 cycles after each request transition.
    always @(negedge clk) begin
        if (resp_en) begin
            if (request != resp_last) begin
                resp_last = request;
                resp_dly  = 5;
                got_words.push_back(request_data);
                got_reqs.push_back(request);
            end else if (resp_dly > 0) begin
                resp_dly--;
                if (resp_dly == 0) resp_ack = resp_last;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send_pulse(input logic [WW-1:0] w);
        input_valid = 1'b1;
        input_data  = w;
        @(negedge clk);
        input_valid = 1'b0;
    endtask

    initial begin
        int k, pulses, first;

        // 1: clear for three cycles
        repeat (3) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check("t1 request",      32'(request),      32'd0);
        check("t1 request_data", 32'(request_data), 32'd0);
        check("t1 busy",         32'(busy),         32'd0);
        check("t1 input_ready",  32'(input_ready),  32'd1);

        // 2: single word, then ack
        send_pulse(8'hA5);
        check("t2 request",      32'(request),      32'd1);
        check("t2 request_data", 32'(request_data), 32'hA5);
        check("t2 busy",         32'(busy),         32'd1);
        man_ack = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (busy && k < 20);
        check("t2 ack latency", 32'(k), 32'(SD + 1));

        // 3: back-to-back words with echoing receiver
        man_ack = 1'b0;
        clear = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        resp_ack = 1'b0; resp_last = 1'b0; resp_dly = 0; resp_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            logic [WW-1:0] w;
            w = (i == 0) ? 8'h01 : 8'h02;
            input_valid = 1'b1;
            input_data  = w;
            k = 0;
            do begin @(negedge clk); k++; end while (!(busy && request_data == w) && k < 60);
            input_valid = 1'b0;
            check("t3 accept bound", 32'(k < 60), 32'd1);
        end
        k = 0;
        do begin @(negedge clk); k++; end while (busy && k < 60);
        check("t3 drain bound", 32'(k < 60), 32'd1);
        check("t3 word count", 32'(got_words.size()), 32'd2);
        if (got_words.size() == 2) begin
            check("t3 word0", 32'(got_words[0]), 32'h01);
            check("t3 word1", 32'(got_words[1]), 32'h02);
            check("t3 req0",  32'(got_reqs[0]),  32'd1);
            check("t3 req1",  32'(got_reqs[1]),  32'd0);
        end

        // 4: timeout with ack withheld
        man_ack = 1'b0;
        resp_en = 1'b0;
        send_pulse(8'h3C);
        check("t4 busy", 32'(busy), 32'd1);
        pulses = 0; first = -1;
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                pulses++;
                if (first < 0) first = j;
            end
        end
        check("t4 timeout cycle",  32'(first),  32'd10);
        check("t4 timeout pulses", 32'(pulses), 32'd1);
        check("t4 still busy",     32'(busy),   32'd1);
        man_ack = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (busy && k < 20);
        check("t4 late ack latency", 32'(k), 32'(SD + 1));

        // 5: ack change while idle
        man_ack = 1'b0;
        pulses = 0; first = -1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (protocol_error === 1'b1) begin
                pulses++;
                if (first < 0) first = j;
            end
        end
        check("t5 perr cycle",  32'(first),       32'(SD));
        check("t5 perr pulses", 32'(pulses),      32'd1);
        check("t5 idle",        32'(input_ready), 32'd1);

        // 6: clear while waiting with request high
        send_pulse(8'h11);
        repeat (3) @(negedge clk);
        check("t6 first done", 32'(busy), 32'd0);
        send_pulse(8'h99);
        check("t6 request high", 32'(request), 32'd1);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t6 request",      32'(request),      32'd0);
        check("t6 busy",         32'(busy),         32'd0);
        check("t6 input_ready",  32'(input_ready),  32'd1);
        check("t6 request_data", 32'(request_data), 32'd0);
        pulses = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (timeout === 1'b1) pulses++;
        end
        check("t6 no timeout", 32'(pulses), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
